tenthirty_ctrl: RTL and testbench
=================================

// Module: tenthirty_ctrl
// PURPOSE
//  Game controller for ten-and-a-half; the requesting side of the deck LUT draw interface.
//  Pulses pip to draw a card, captures number one cycle later and scores it in half-points.
//  Plays the player hand, then the dealer hand, each with a fixed stand threshold.
//  Judges the winner and reports it.
//  Sits between the top-level start control and the deck LUT.
// PARAMETERS
//  PLAYER_TH  14  player stands when player_pts >= PLAYER_TH (half-points; 14 = 7.0)
//  DEALER_TH  16  dealer stands when dealer_pts >= DEALER_TH (16 = 8.0)
//  MAX_CARDS  5   maximum cards per hand; a hand stands when it reaches this count
// PORTS
//  clk         in   1  clock, all logic on rising edge
//  rst_n       in   1  synchronous active-low reset
//  start       in   1  1-cycle request to play one game; ignored unless state==IDLE
//  number      in   4  card from deck, valid the cycle after pip; 1..13, 0 = no card
//  empty       in   1  deck exhausted flag from deck
//  pip         out  1  draw request, registered, high exactly 1 cycle per card
//  busy        out  1  high in every state except IDLE
//  done        out  1  1-cycle pulse when result/points become final
//  result      out  2  01 player win, 10 dealer win, 11 tie, 00 aborted (deck ran out)
//  player_pts  out  6  player hand total in half-points, held until next start
//  dealer_pts  out  6  dealer hand total in half-points, held until next start
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=IDLE; all outputs 0; card counters 0.
//   - Applies mid-game too; no pending draw survives.
//  Card value (half-points): number 1..10 -> 2*number; 11,12,13 -> 1. Totals fit 6 bits, max 40.
//  FSM: IDLE -> P_REQ -> P_CAP -> P_CHK -> (P_REQ | D_REQ | DONE)
//       D_REQ -> D_CAP -> D_CHK -> (D_REQ | JUDGE) -> DONE -> IDLE
//  IDLE
//   - start=1: clear player_pts, dealer_pts, result and both counters.
//   - If empty=1, go to DONE with result 00; otherwise go to P_REQ.
//  P_REQ / D_REQ
//   - pip=1 for this cycle only.
//   - If empty=1 on entry, no pip is asserted; go to DONE with result 00.
//  P_CAP / D_CAP
//   - number=0: go to DONE with result 00; the total is not updated.
//   - Otherwise add the card value to the hand total and increment the hand's card count.
//  P_CHK
//   - pts>21: bust; result=10; go to DONE (dealer draws nothing).
//   - pts>=PLAYER_TH, pts==21, or count==MAX_CARDS: go to D_REQ.
//   - Otherwise: go to P_REQ.
//  D_CHK
//   - pts>21: result=01; go to DONE.
//   - pts>=DEALER_TH, pts==21, or count==MAX_CARDS: go to JUDGE.
//   - Otherwise: go to D_REQ.
//  JUDGE: player>dealer -> 01; dealer>player -> 10; equal -> 11; go to DONE.
//  DONE: done=1 for one cycle; busy stays 1; go to IDLE.
//  Timing:
//   - 3 cycles per card; pip is never high in consecutive cycles.
//   - start while busy=1 has no effect.
//  Output holding:
//   - result and both totals hold their values in IDLE until the next accepted start.
//   - Totals are never cleared by done.
// TESTING (deck LUT model in fixed order 10,13,8,2,10,2,7,11,6,5,...)
//  1. Game 1, start pulse:
//     - pips=3; player 10 -> 20, stands; dealer 13,8 -> 17, stands.
//     - Expect player_pts=20, dealer_pts=17, result=01, done pulses once.
//  2. Game 2, start after game 1:
//     - player 2,10 -> 24, bust.
//     - Expect result=10, dealer_pts=0, pips=2.
//  3. Game 3:
//     - player 2,7 -> 18; dealer 11,6,5 -> 1,13,23, bust.
//     - Expect result=01, pips=5.
//  4. Stub deck, empty=1 before start:
//     - Expect pip never asserted, result=00, done pulses once.
//  5. Stub returns number=0 on the first draw:
//     - Expect result=00, player_pts=0.
//  6. Timing and reset checks:
//     - start during busy is ignored.
//     - rst_n=0 asserted in D_CAP: next cycle all outputs 0, state IDLE, no further pip.
//  7. Stub all-13 deck:
//     - Player stops at MAX_CARDS with player_pts=5; dealer likewise 5.
//     - Expect result=11.

Source files
------------

// File: rtl/tenthirty_if.sv
// Deck draw bus: the controller pulses pip, and the deck answers with number
// on the following cycle. empty is the deck's exhausted flag.
interface tenthirty_if;
    logic       pip;
    logic [3:0] number;
    logic       empty;

    modport master (output pip, input number, input empty);
    modport slave  (input pip, output number, output empty);
endinterface

// File: rtl/tenthirty_ctrl.sv
// Ten-and-a-half game controller. Draws cards from the deck over the draw bus,
// scores them in half-points, plays the player hand and then the dealer hand,
// and reports the winner.
module tenthirty_ctrl #(
    parameter int PLAYER_TH = 14,
    parameter int DEALER_TH = 16,
    parameter int MAX_CARDS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    tenthirty_if.master deck,
    output logic        busy,
    output logic        done,
    output logic [1:0]  result,
    output logic [5:0]  player_pts,
    output logic [5:0]  dealer_pts
);

    localparam int CW = $clog2(MAX_CARDS + 1);

    localparam logic [1:0] RES_ABORT  = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_DEALER = 2'b10;
    localparam logic [1:0] RES_TIE    = 2'b11;

    typedef enum logic [3:0] {
        IDLE, P_REQ, P_CAP, P_CHK, D_REQ, D_CAP, D_CHK, JUDGE, DONE
    } state_t;

    state_t        state_q, state_d;
    logic          pip_q, pip_d;
    logic [1:0]    result_q, result_d;
    logic [5:0]    ppts_q, ppts_d;
    logic [5:0]    dpts_q, dpts_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic [5:0]    card_val;
    logic          p_stand, d_stand;

    // Face cards score half a point, number cards score their face value.
    always_comb begin
        card_val = 6'd1;
        if (deck.number >= 4'd1 && deck.number <= 4'd10)
            card_val = {1'b0, deck.number, 1'b0};
    end

    // Stand decisions from the registered totals and card counts.
    always_comb begin
        p_stand = (ppts_q >= 6'(PLAYER_TH)) || (ppts_q == 6'd21) || (pcnt_q == CW'(MAX_CARDS));
        d_stand = (dpts_q >= 6'(DEALER_TH)) || (dpts_q == 6'd21) || (dcnt_q == CW'(MAX_CARDS));
    end

    // Next-state and datapath updates. pip is decided on the cycle that enters
    // a REQ state so it is a clean registered pulse; a REQ state entered with
    // pip low means the deck was empty and the game aborts.
    always_comb begin
        state_d  = state_q;
        pip_d    = 1'b0;
        result_d = result_q;
        ppts_d   = ppts_q;
        dpts_d   = dpts_q;
        pcnt_d   = pcnt_q;
        dcnt_d   = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    result_d = RES_ABORT;
                    ppts_d   = '0;
                    dpts_d   = '0;
                    pcnt_d   = '0;
                    dcnt_d   = '0;
                    if (deck.empty) begin
                        state_d = DONE;
                    end else begin
                        state_d = P_REQ;
                        pip_d   = 1'b1;
                    end
                end
            end
            P_REQ: begin
                if (pip_q) state_d = P_CAP;
                else begin
                    state_d  = DONE;
                    result_d = RES_ABORT;
                end
            end
            P_CAP: begin
                if (deck.number == 4'd0) begin
                    state_d  = DONE;
                    result_d = RES_ABORT;
                end else begin
                    ppts_d  = ppts_q + card_val;
                    pcnt_d  = pcnt_q + 1'b1;
                    state_d = P_CHK;
                end
            end
            P_CHK: begin
                if (ppts_q > 6'd21) begin
                    state_d  = DONE;
                    result_d = RES_DEALER;
                end else begin
                    state_d = p_stand ? D_REQ : P_REQ;
                    pip_d   = !deck.empty;
                end
            end
            D_REQ: begin
                if (pip_q) state_d = D_CAP;
                else begin
                    state_d  = DONE;
                    result_d = RES_ABORT;
                end
            end
            D_CAP: begin
                if (deck.number == 4'd0) begin
                    state_d  = DONE;
                    result_d = RES_ABORT;
                end else begin
                    dpts_d  = dpts_q + card_val;
                    dcnt_d  = dcnt_q + 1'b1;
                    state_d = D_CHK;
                end
            end
            D_CHK: begin
                if (dpts_q > 6'd21) begin
                    state_d  = DONE;
                    result_d = RES_PLAYER;
                end else if (d_stand) begin
                    state_d = JUDGE;
                end else begin
                    state_d = D_REQ;
                    pip_d   = !deck.empty;
                end
            end
            JUDGE: begin
                state_d = DONE;
                if (ppts_q > dpts_q)      result_d = RES_PLAYER;
                else if (dpts_q > ppts_q) result_d = RES_DEALER;
                else                      result_d = RES_TIE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset also kills any pending draw.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pip_q    <= 1'b0;
            result_q <= '0;
            ppts_q   <= '0;
            dpts_q   <= '0;
            pcnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pip_q    <= pip_d;
            result_q <= result_d;
            ppts_q   <= ppts_d;
            dpts_q   <= dpts_d;
            pcnt_q   <= pcnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign deck.pip   = pip_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign result     = result_q;
    assign player_pts = ppts_q;
    assign dealer_pts = dpts_q;

endmodule

// File: tb/tb_tenthirty_ctrl.sv
// Bench for tenthirty_ctrl: deck model on the draw bus, expected game outcomes
// queued at start, and a monitor that checks each done pulse against the queue.
module tb_tenthirty_ctrl;

    typedef struct {
        logic [1:0] res;
        int         pp;
        int         dp;
        int         pips;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [1:0] result;
    logic [5:0] player_pts, dealer_pts;

    tenthirty_if deck ();

    tenthirty_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .deck       (deck.master),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .player_pts (player_pts),
        .dealer_pts (dealer_pts)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    int   pipcnt = 0;
    logic prev_pip = 1'b0;
    logic prev_done = 1'b0;

    // deck modes: 0 fixed sequence, 1 all thirteens, 2 no card
    int   mode = 0;
    int   idx = 0;
    int   seq [10] = '{10, 13, 8, 2, 10, 2, 7, 11, 6, 5};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Deck model: answers a pip with the next card, valid through the capture cycle.
    initial begin
        deck.number = 4'd0;
        deck.empty  = 1'b0;
        forever begin
            @(negedge clk);
            if (deck.pip) begin
                case (mode)
                    0: begin
                        deck.number = (idx < 10) ? 4'(seq[idx]) : 4'd0;
                        idx++;
                    end
                    1: deck.number = 4'd13;
                    default: deck.number = 4'd0;
                endcase
            end
        end
    end

    // Monitor: pip spacing, single-cycle done, and scoreboard compare on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pipcnt = 0;
            end else begin
                if (deck.pip) begin
                    check("pip_gap", int'(prev_pip), 0);
                    pipcnt++;
                end
                if (done) begin
                    check("done_width", int'(prev_done), 0);
                    check("busy_in_done", int'(busy), 1);
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("result", int'(result), int'(e.res));
                        check("player_pts", int'(player_pts), e.pp);
                        check("dealer_pts", int'(dealer_pts), e.dp);
                        check("pips", pipcnt, e.pips);
                    end
                    pipcnt = 0;
                end
            end
            prev_pip  = deck.pip;
            prev_done = done;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic play(input logic [1:0] r, input int pp, input int dp, input int pips);
        exp_t e;
        e.res = r; e.pp = pp; e.dp = dp; e.pips = pips;
        sb.push_back(e);
        pulse_start();
        wait_idle();
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pip", int'(deck.pip), 0);
        check("rst_result", int'(result), 0);
        check("rst_pts", int'({player_pts, dealer_pts}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed-order deck games
        play(2'b01, 20, 17, 3);
        repeat (5) @(negedge clk);
        check("hold_result", int'(result), 1);
        check("hold_player", int'(player_pts), 20);
        check("hold_dealer", int'(dealer_pts), 17);
        play(2'b10, 24, 0, 2);
        play(2'b01, 18, 23, 5);

        // Deck empty before start
        deck.empty = 1'b1;
        play(2'b00, 0, 0, 0);
        deck.empty = 1'b0;

        // Deck returns no card on first draw
        mode = 2;
        play(2'b00, 0, 0, 1);

        // All-thirteen deck, with a stray start mid-game that must be ignored
        mode = 1;
        begin
            exp_t e;
            e.res = 2'b11; e.pp = 5; e.dp = 5; e.pips = 10;
            sb.push_back(e);
        end
        pulse_start();
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (30) @(negedge clk);
        check("busy_after_game", int'(busy), 0);
        check("sb_empty", sb.size(), 0);

        // Reset during the dealer's first capture
        pulse_start();
        n = (deck.pip) ? 1 : 0;
        for (int c = 0; c < 100 && n < 6; c++) begin
            @(negedge clk);
            if (deck.pip) n++;
        end
        check("reach_dealer_pip", n, 6);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        check("mid_rst_pip", int'(deck.pip), 0);
        check("mid_rst_result", int'(result), 0);
        check("mid_rst_player", int'(player_pts), 0);
        check("mid_rst_dealer", int'(dealer_pts), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (deck.pip || busy) n++;
        end
        check("quiet_after_rst", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
